// File: rtl/alu_mul_seq_pkg.sv
// Shared constants for the shift-and-add multiplier sequencer: the ALU control
// words it issues and its state encoding.
package alu_mul_seq_pkg;

    // Hack ALU control word order: {zx, nx, zy, ny, f, no}
    localparam logic [5:0] ALU_ZERO   = 6'b101010;
    localparam logic [5:0] ALU_XPLUSY = 6'b000010;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_ADD  = 3'd2,
        S_DBL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/response handshake bundle between a requester and the multiplier
// sequencer.
interface alu_mul_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] product;
    logic             zr;
    logic             ng;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, zr, ng
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, zr, ng
    );
endinterface

// File: rtl/hack_alu.sv
// Combinational Hack ALU shared by several bus masters; the multiplier
// sequencer only drives its operands and control bits.
module hack_alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] x_z, x_n, y_z, y_n, res;

    always_comb begin
        x_z = zx ? '0 : x;
        x_n = nx ? ~x_z : x_z;
        y_z = zy ? '0 : y;
        y_n = ny ? ~y_z : y_z;
        res = f ? (x_n + y_n) : (x_n & y_n);
        out = no ? ~res : res;
    end
endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle multiplier that computes a*b mod 2^WIDTH by steering an external
// Hack ALU through clear / add / double steps; it owns no adder of its own.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_mul_seq_if.slave     bus,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out
);
    state_t           state, state_n;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b_shr;
    logic [5:0]       ctrl;

    assign b_shr = b_reg >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        ctrl         = ALU_ZERO;
        alu_x        = '0;
        alu_y        = '0;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_n = S_CLR;
            end
            S_CLR: begin
                if (b_reg == '0)   state_n = S_DONE;
                else if (b_reg[0]) state_n = S_ADD;
                else               state_n = S_DBL;
            end
            S_ADD: begin
                ctrl  = ALU_XPLUSY;
                alu_x = acc;
                alu_y = a_reg;
                // ADD leaves B alone; the following DBL consumes bit 0.
                if (b_shr == '0) state_n = S_DONE;
                else             state_n = S_DBL;
            end
            S_DBL: begin
                ctrl  = ALU_XPLUSY;
                alu_x = a_reg;
                alu_y = a_reg;
                if (b_shr == '0)   state_n = S_DONE;
                else if (b_shr[0]) state_n = S_ADD;
                else               state_n = S_DBL;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;

    // ALU results are captured the same cycle they are driven.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b;
                    end
                end
                S_CLR, S_ADD: acc <= alu_out;
                S_DBL: begin
                    a_reg <= alu_out;
                    b_reg <= b_shr;
                end
                default: ;
            endcase
        end
    end

    assign bus.product = acc;
    assign bus.zr      = (acc == '0);
    assign bus.ng      = acc[WIDTH-1];
endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized bench for alu_mul_seq driving the real Hack ALU, checked against
// a plain-arithmetic product/latency model.
module tb_alu_mul_seq;
    logic        clk;
    logic        reset;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [5:0]  ctrl_w;
    int          n_vec;
    int          n_err;

    alu_mul_seq_if #(.WIDTH(16)) bus ();

    alu_mul_seq #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .alu_x   (alu_x),
        .alu_y   (alu_y),
        .alu_zx  (alu_zx),
        .alu_nx  (alu_nx),
        .alu_zy  (alu_zy),
        .alu_ny  (alu_ny),
        .alu_f   (alu_f),
        .alu_no  (alu_no),
        .alu_out (alu_out)
    );

    hack_alu #(.WIDTH(16)) alu (
        .x   (alu_x),
        .y   (alu_y),
        .zx  (alu_zx),
        .nx  (alu_nx),
        .zy  (alu_zy),
        .ny  (alu_ny),
        .f   (alu_f),
        .no  (alu_no),
        .out (alu_out)
    );

    assign ctrl_w = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] bv);
        int msb;
        if (bv == 16'h0) return 1;
        msb = 0;
        for (int i = 0; i < 16; i++) if (bv[i]) msb = i;
        return 1 + $countones(bv) + msb;
    endfunction

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One request: accept, wait for the product, optionally stall, release.
    task automatic run_req(input logic [15:0] av, input logic [15:0] bv, input int hold);
        int          lat;
        logic [5:0]  ctl[$];
        logic [31:0] full;
        logic [15:0] pexp;
        full = {16'h0, av} * {16'h0, bv};
        pexp = full[15:0];
        check("idle_in_ready", {31'h0, bus.in_ready}, 32'h1);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        @(negedge clk);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            ctl.push_back(ctrl_w);
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            check("timeout_out_valid", 32'h0, 32'h1);
            do_reset();
            return;
        end
        check("latency", lat, exp_lat(bv));
        check("product", {16'h0, bus.product}, {16'h0, pexp});
        check("zr", {31'h0, bus.zr}, {31'h0, pexp == 16'h0});
        check("ng", {31'h0, bus.ng}, {31'h0, pexp[15]});
        check("done_ctrl", {26'h0, ctrl_w}, {26'h0, 6'b101010});
        for (int i = 0; i < ctl.size(); i++)
            check("ctrl_seq", {26'h0, ctl[i]}, (i == 0) ? 32'h2A : 32'h02);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom);
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            @(negedge clk);
            check("hold_product", {16'h0, bus.product}, {16'h0, pexp});
            check("hold_out_valid", {31'h0, bus.out_valid}, 32'h1);
            check("hold_in_ready", {31'h0, bus.in_ready}, 32'h0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = (hold > 0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("bubble_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("bubble_out_valid", {31'h0, bus.out_valid}, 32'h0);
    endtask

    initial begin
        int          seen;
        logic [15:0] ra, rb;
        n_vec         = 0;
        n_err         = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 16'h0;
        bus.b         = 16'h0;
        do_reset();
        @(negedge clk);

        check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_product", {16'h0, bus.product}, 32'h0);
        check("rst_zr", {31'h0, bus.zr}, 32'h1);
        check("rst_ng", {31'h0, bus.ng}, 32'h0);
        check("rst_ctrl", {26'h0, ctrl_w}, 32'h2A);
        check("rst_alu_x", {16'h0, alu_x}, 32'h0);
        check("rst_alu_y", {16'h0, alu_y}, 32'h0);

        // Reset in the middle of a long multiply discards it.
        bus.a = 16'd7; bus.b = 16'hFFFF; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("midrst_zr", {31'h0, bus.zr}, 32'h1);
        check("midrst_product", {16'h0, bus.product}, 32'h0);
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midrst_no_out_valid", seen, 0);

        run_req(16'd3, 16'd5, 0);
        run_req(16'h1234, 16'h0000, 0);
        run_req(16'hFFFF, 16'h0003, 0);
        run_req(16'h0100, 16'h0100, 0);
        run_req(16'hFFFF, 16'hFFFF, 0);
        run_req(16'h00AB, 16'h0011, 5);

        for (int t = 0; t < 40; t++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'($urandom_range(0, 15));
                1:       rb = 16'h1 << $urandom_range(0, 15);
                2:       rb = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0;
                default: rb = 16'($urandom);
            endcase
            run_req(ra, rb, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 16-bit multiplier controller that sequences the shared Hack ALU to compute `a*b mod 2^WIDTH` by shift-and-add. It does not add its own adder. It sits between a requester (CPU extension or memory-mapped math unit) and the combinational ALU. It drives the ALU's x/y operands and six control bits each cycle, and captures the ALU result at the clock edge. Valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 16, operand/result width; must match the ALU width.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  request valid
- `in_ready`  out  1  controller can accept a request; high only in IDLE
- `a`, `b`  in  WIDTH  multiplicand, multiplier; sampled on accept
- `out_valid`  out  1  product valid; high only in DONE
- `out_ready`  in  1  consumer accepts the product
- `product`  out  WIDTH  low WIDTH bits of a*b; equal to `acc`
- `zr`, `ng`  out  1  `product==0`, `product[WIDTH-1]`
- `alu_x`, `alu_y`  out  WIDTH  ALU operands
- `alu_zx`, `alu_nx`, `alu_zy`, `alu_ny`, `alu_f`, `alu_no`  out  1 each  ALU control
- `alu_out`  in  WIDTH  combinational ALU result

## Operation
- Registers:
  - `A` is the shifted multiplicand.
  - `B` is the remaining multiplier, shifted right locally.
  - `acc` is the accumulator.
  - `state` is one of IDLE, CLR, ADD, DBL, DONE.
- IDLE:
  - ALU driven with the ZERO control word `101010`, x=y=0.
  - On `in_valid`: `A<=a`, `B<=b`, go to CLR.
- CLR:
  - ALU ZERO word; `acc<=alu_out` (0).
  - Next state: DONE if `B==0`; else ADD if `B[0]`; else DBL.
- ADD:
  - ALU x=`acc`, y=`A`, control `000010` (x+y); `acc<=alu_out`.
  - Next state: DONE if `B[WIDTH-1:1]==0`, else DBL.
- DBL:
  - ALU x=`A`, y=`A`, control `000010`; `A<=alu_out`; `B<=B>>1`.
  - Let `Bn` be the shifted value. Next state: DONE if `Bn==0`; else ADD if `Bn[0]`; else DBL.
- DONE:
  - ALU ZERO word; `out_valid=1`; `product`, `zr` and `ng` come from `acc`.
  - On `out_ready`: go to IDLE.
- Arithmetic is modulo 2^WIDTH; carries out of the MSB are dropped by the ALU.
- The result is correct for two's-complement signed operands as well as unsigned ones.
- `zr`/`ng` are valid whenever `out_valid` is high; they are don't-care otherwise but must still equal the function of `acc`.

## Timing
- Reset values:
  - `state`=IDLE, `A`=`B`=`acc`=0.
  - `in_ready`=1, `out_valid`=0, `product`=0, `zr`=1, `ng`=0.
  - ALU control = `101010`, `alu_x`=`alu_y`=0.
- Latency from the accept edge to the first `out_valid` cycle is N = 1 + popcount(b) + msb_index(b) cycles, with N=1 for b=0.
  - Example: b=5 gives 5. Maximum is 32, for b=0xFFFF.
- `in_valid` while not in IDLE is ignored (`in_ready`=0); `a`/`b` are not sampled.
- `out_valid` holds, and `product` stays stable, until `out_ready`. No timeout.
- DONE with `out_ready` returns to IDLE at the next edge; a new request is accepted at the earliest on the following edge (one-cycle bubble).
- ALU outputs are a pure function of `state`/`A`/`acc`. ALU results are captured in the same cycle they are driven; there is no registered ALU path.
- `reset` asserted in any state returns to reset values at the next edge. Any in-flight result is discarded and no `out_valid` is produced for it.

## Structure
- Shared package/header:
  - ALU control word constants: ALU_ZERO=6'b101010, ALU_XPLUSY=6'b000010.
  - State encoding, 3 bits.
- Single module, no sub-modules; the ALU stays external so other masters can share it.
- The bench instantiates the team's 16-bit ALU and connects it to the `alu_*` ports.

## Test plan
- Reset mid-run: a=7, b=0xFFFF, reset asserted at cycle 10 -> IDLE next edge, `out_valid` never rises, `in_ready`=1, `zr`=1.
- a=3, b=5 -> `out_valid` after 5 cycles, `product`=15, `zr`=0, `ng`=0; the ALU control sequence observed is ZERO, x+y, x+y, x+y, x+y.
- a=0x1234, b=0 -> `out_valid` after 1 cycle, `product`=0, `zr`=1.
- a=0xFFFF (-1), b=0x0003 -> `product`=0xFFFD, `ng`=1; a=0x0100, b=0x0100 -> `product`=0 (wrap), `zr`=1.
- a=0xFFFF, b=0xFFFF -> 32-cycle latency, `product`=0x0001.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE -> `product` stable, `in_ready`=0; pulsing `in_valid` meanwhile is ignored. Release -> IDLE, next request accepted one cycle later.
